// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared FSM state, default width and counter-width helper for the serial adder
`timescale 1ns/1ps
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    // A 1-bit counter is kept even for degenerate widths so the port never collapses to zero bits.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/somador_completo.sv
// rtl/somador_completo.sv - combinational one-bit full adder cell
`timescale 1ns/1ps
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/somador_serial_8bits.sv
// rtl/somador_serial_8bits.sv - bit-serial adder with start/done handshake; SOMADOR_OVERFLOW_FLAG_EN adds signed-overflow output V
`timescale 1ns/1ps
module somador_serial_8bits
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
`ifdef SOMADOR_OVERFLOW_FLAG_EN
    output logic             V,
`endif
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
    logic             v_q, v_d;
`endif

    logic fa_s;
    logic fa_cout;

    somador_completo u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
        v_d     = v_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    s_d     = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
                    v_d     = carry_q ^ fa_cout;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
            v_q     <= v_d;
`endif
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
    assign V    = v_q;
`endif
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_somador_serial_8bits.sv
// tb/tb_somador_serial_8bits.sv - self-checking bench for somador_serial_8bits (vectors, corner sequences, random scoreboard)
`timescale 1ns/1ps
module tb_somador_serial_8bits;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] S;
    logic       Cout;
    logic       busy;
    logic       done;
`ifdef SOMADOR_OVERFLOW_FLAG_EN
    logic       V;
`endif

    int checks = 0;
    int errors = 0;

    somador_serial_8bits #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout),
`ifdef SOMADOR_OVERFLOW_FLAG_EN
        .V     (V),
`endif
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_v(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int r;
        r = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (r > 127) || (r < -128);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the number of edges from the accepting edge to the cycle where done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_calc", busy, 1);
            if (done) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    vec_t       vecs [7];
    logic [16:0] hist [13000];
    int         lat;
    int         last_done;
    int         ndone;
    logic       prev_done;
    logic [7:0] ea, eb;
    logic       ec;
    logic       hold_ok;
    logic       saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};

        do_reset();
        @(negedge clk);
        chk("rst_S", S, 8'h00);
        chk("rst_Cout", Cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef SOMADOR_OVERFLOW_FLAG_EN
        chk("rst_V", V, 0);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk("latency", lat, 8);
            chk("vec_S", S, vecs[i].s);
            chk("vec_Cout", Cout, vecs[i].cout);
`ifdef SOMADOR_OVERFLOW_FLAG_EN
            chk("vec_V", V, vecs[i].v);
`endif
            chk("busy_done", busy, 1);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_idle", busy, 0);
        end

        // Result must hold while inputs toggle with no start.
        hold_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
            @(negedge clk);
            if (S !== 8'h01 || Cout !== 1'b1 || done !== 1'b0) hold_ok = 1'b0;
        end
        chk("hold_result", hold_ok, 1);

        // Reset in the middle of CALC aborts the operation without a done pulse.
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_S", S, 8'h00);
        chk("abort_Cout", Cout, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);

        // start held high with operands changing every cycle; each result must
        // match the operands presented on its accepting edge.
        do_reset();
        last_done = -1;
        ndone = 0;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 13000 && ndone < 1000; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (done) begin
                    chk("done_twice", prev_done, 0);
                    if (cyc >= 9) begin
                        {ec, ea, eb} = hist[cyc - 9];
                        chk("rand_sum", {Cout, S}, 9'(ea) + 9'(eb) + 9'(ec));
`ifdef SOMADOR_OVERFLOW_FLAG_EN
                        chk("rand_V", V, model_v(ea, eb, ec));
`endif
                    end else begin
                        chk("rand_early_done", cyc, 9);
                    end
                    if (last_done >= 0) chk("spacing", cyc - last_done, 10);
                    else chk("first_latency", cyc, 9);
                    last_done = cyc;
                    ndone++;
                end
                prev_done = done;
            end
            A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
            start = 1'b1;
            hist[cyc] = {Cin, A, B};
        end
        chk("rand_ops", ndone, 1000);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
